serial_full_add: RTL

SERIAL_FULL_ADD -- requirements
Module: serial_full_add

---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/full_adder_bfl.sv | 17 +
 rtl/serial_full_add.sv | 124 ++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic cells.
// Holds the sequencer state encoding and the default datapath width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder_bfl.sv
// One-bit combinational full adder cell.
// Companion of the one-bit subtractor cell used by the serial subtractor.
module full_adder_bfl (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic half;

    assign half  = a ^ b;
    assign sum   = half ^ cin;
    assign carry = (a & b) | (cin & half);

endmodule

// File: rtl/serial_full_add.sv
// Bit-serial adder: one full-adder cell and one carry flop, LSB first.
// Result and carry-out are published only when the last bit is done.
import serial_arith_pkg::*;

module serial_full_add #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_n;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic             last;
    logic [WIDTH-1:0] full;

    full_adder_bfl u_fa (
        .sum   (fa_sum),
        .carry (fa_carry),
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry)
    );

    assign last = (cnt == LAST);
    assign full = {fa_sum, acc};
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: accept in IDLE, run WIDTH bits, one DONE cycle.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and carry propagation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_carry;
                    acc   <= full[WIDTH-1:1];
                    cnt   <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Publish the whole result at once on the last bit so it never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == SHIFT && last) begin
            sum  <= full;
            cout <= fa_carry;
        end
    end

endmodule
